// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_queue_unit
// Brief  : Instruction fetch with in-line branch resolver and {pc,instr} queue
// Rev    : 1.0
// ============================================================================
module fetch_queue_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    input  logic [3:0]        cond_flags,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              br_taken
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] req_pc;
    logic [ADDR_W-1:0] q_pc    [QDEPTH];
    logic [31:0]       q_instr [QDEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              resp, push, pop;
    logic              is_branch, cond_true, take_branch;
    logic [3:0]        br_cond;
    logic              flag_n, flag_c, flag_z, flag_v, sgn_ge;
    logic [ADDR_W-1:0] br_offset, br_sum, br_target;
    logic              unused_bits;

    assign imem_req  = (state == ST_IDLE) && (count < DEPTH_C) && !redirect_valid && !reset;
    assign imem_addr = fetch_pc;
    assign id_valid  = (count != '0);
    assign id_instr  = q_instr[rd_ptr];
    assign id_pc     = q_pc[rd_ptr];

    // A redirect in the same cycle kills both the incoming word and any pop.
    assign resp = (state == ST_WAIT) && imem_valid;
    assign push = resp && !redirect_valid;
    assign pop  = id_valid && id_ready && !redirect_valid;

    assign is_branch = (imem_rdata[31:29] == 3'b110);
    assign br_cond   = imem_rdata[28:25];
    assign flag_n    = cond_flags[3];
    assign flag_c    = cond_flags[2];
    assign flag_z    = cond_flags[1];
    assign flag_v    = cond_flags[0];
    assign sgn_ge    = (flag_n == flag_v);

    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            4'h0:    cond_true = flag_z;
            4'h1:    cond_true = !flag_z;
            4'h2:    cond_true = flag_c;
            4'h3:    cond_true = !flag_c;
            4'h4:    cond_true = flag_n;
            4'h5:    cond_true = !flag_n;
            4'h6:    cond_true = flag_v;
            4'h7:    cond_true = !flag_v;
            4'h8:    cond_true = flag_c && !flag_z;
            4'h9:    cond_true = !(flag_c && !flag_z);
            4'hA:    cond_true = sgn_ge;
            4'hB:    cond_true = !sgn_ge;
            4'hC:    cond_true = !flag_z && sgn_ge;
            4'hD:    cond_true = !(!flag_z && sgn_ge);
            4'hE:    cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign br_offset   = ADDR_W'($signed(imem_rdata[15:0]));
    assign br_sum      = req_pc + br_offset;
    assign br_target   = {br_sum[ADDR_W-1:2], 2'b00};
    assign take_branch = resp && is_branch && cond_true;
    assign unused_bits = ^{imem_rdata[24:16], redirect_pc[1:0], br_sum[1:0]};

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (imem_req) state_next = ST_WAIT;
            ST_WAIT: begin
                if (imem_valid)          state_next = ST_IDLE;
                else if (redirect_valid) state_next = ST_DISCARD;
            end
            ST_DISCARD: if (imem_valid) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            br_taken <= 1'b0;
        end else begin
            br_taken <= take_branch && !redirect_valid;
            if (imem_req) req_pc <= fetch_pc;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (resp) fetch_pc <= take_branch ? br_target : req_pc + ADDR_W'(4);
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= req_pc;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_queue_unit
// Brief  : Randomised and directed bench for fetch_queue_unit against a
//          program-flow reference model (expected word stream + next PC).
// Rev    : 1.0
// ============================================================================
module tb_fetch_queue_unit;

    localparam int          AW     = 32;
    localparam int          QD     = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_valid = 1'b0;
    logic [31:0]   imem_rdata = '0;
    logic [3:0]    cond_flags = '0;
    logic          id_valid;
    logic [31:0]   id_instr;
    logic [AW-1:0] id_pc;
    logic          id_ready = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [AW-1:0] fetch_pc;
    logic          br_taken;

    fetch_queue_unit #(.ADDR_W(AW), .QDEPTH(QD), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .cond_flags(cond_flags),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_pc(fetch_pc), .br_taken(br_taken)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;

    // Reference model: words the program flow should deliver, and next fetch PC.
    logic [63:0] exp_q [$];
    logic [31:0] model_pc;
    bit          pend_valid, pend_drop, exp_br;
    logic [31:0] pend_addr;
    int          pend_rem;
    logic [31:0] mem [logic [31:0]];

    // Observations of the DUT for directed checks.
    logic [31:0] req_log [$];
    int          req_cyc [$];
    logic [63:0] pop_log [$];
    int          cyc, br_cnt, id_first_cyc;

    // Stimulus knobs.
    int          ready_pct, lat_min, lat_max, redir_pct, spur_pct;
    bit          mem_rand, flags_rand;
    logic [3:0]  flags;
    logic [31:0] redir_pcs [$];
    bit          redir_arm, slow_en;
    logic [31:0] redir_at_addr, redir_target, slow_addr;
    int          redir_delay, redir_cnt, slow_lat;

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 99) < 30) begin
            w[31:29] = 3'b110;
            w[15:0]  = 16'($urandom_range(0, 511)) - 16'd256;
        end else if (w[31:29] == 3'b110) begin
            w[31] = 1'b0;
        end
        return w;
    endfunction

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        if (!mem.exists(a)) mem[a] = mem_rand ? rand_word() : 32'h0;
        return mem[a];
    endfunction

    function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
        bit n, cy, z, v, gt;
        n = f[3]; cy = f[2]; z = f[1]; v = f[0];
        gt = !z && (n == v);
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return gt;
            4'hD: return !gt;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] req_at(int i);
        return (i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic int cyc_at(int i);
        return (i < req_cyc.size()) ? req_cyc[i] : -1000;
    endfunction

    function automatic logic [63:0] pop_at(int i);
        return (i < pop_log.size()) ? pop_log[i] : 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    task automatic reset_model();
        exp_q.delete(); req_log.delete(); req_cyc.delete(); pop_log.delete();
        mem.delete(); redir_pcs.delete();
        model_pc = RST_PC; pend_valid = 0; pend_drop = 0; pend_rem = 0; pend_addr = '0;
        exp_br = 0; cyc = 0; br_cnt = 0; id_first_cyc = -1;
        ready_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0; spur_pct = 0;
        mem_rand = 0; flags_rand = 0; flags = 4'h0;
        redir_arm = 0; redir_at_addr = '0; redir_target = '0; redir_delay = 0; redir_cnt = 0;
        slow_en = 0; slow_addr = '0; slow_lat = 1;
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0; imem_valid = 1'b0; id_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        reset_model();
    endtask

    // One clock: drive inputs, compare DUT against the model, advance the model.
    task automatic cycle();
        bit          rdy, rv, iv, resp, exp_req, tk, exp_idv;
        logic [31:0] rpc, w;
        logic [63:0] e;
        cyc++;
        rdy = ($urandom_range(0, 99) < ready_pct);
        if (flags_rand) flags = 4'($urandom);
        rv = 0; rpc = '0;
        if (redir_pcs.size() != 0) begin
            rv = 1; rpc = redir_pcs.pop_front();
        end else if (redir_cnt != 0) begin
            redir_cnt--;
            if (redir_cnt == 0) begin rv = 1; rpc = redir_target; end
        end else if ($urandom_range(0, 99) < redir_pct) begin
            rv = 1; rpc = $urandom;
        end
        iv = 0; resp = 0; w = $urandom;
        if (pend_valid) begin
            pend_rem--;
            if (pend_rem == 0) begin iv = 1; resp = 1; w = mem_rd(pend_addr); end
        end else if ($urandom_range(0, 99) < spur_pct) begin
            iv = 1;
        end
        id_ready = rdy; cond_flags = flags; redirect_valid = rv; redirect_pc = rpc;
        imem_valid = iv; imem_rdata = w;
        exp_req = !pend_valid && (exp_q.size() < QD) && !rv;
        exp_idv = (exp_q.size() != 0);
        #1;
        tests_run++;
        if (br_taken !== exp_br) begin
            fails++; $display("FAIL br_taken cyc=%0d got=%b exp=%b", cyc, br_taken, exp_br);
        end
        tests_run++;
        if (id_valid !== exp_idv) begin
            fails++; $display("FAIL id_valid cyc=%0d got=%b exp=%b", cyc, id_valid, exp_idv);
        end
        if (exp_idv) begin
            tests_run++;
            if ({id_pc, id_instr} !== exp_q[0]) begin
                fails++; $display("FAIL id_head cyc=%0d got=%h exp=%h", cyc, {id_pc, id_instr}, exp_q[0]);
            end
        end
        tests_run++;
        if (imem_req !== exp_req) begin
            fails++; $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req);
        end
        if (exp_req) begin
            tests_run++;
            if (imem_addr !== model_pc) begin
                fails++; $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, model_pc);
            end
        end
        if (imem_req === 1'b1) begin req_log.push_back(imem_addr); req_cyc.push_back(cyc); end
        if (id_valid === 1'b1 && rdy && !rv) pop_log.push_back({id_pc, id_instr});
        if (br_taken === 1'b1) br_cnt++;
        if (id_valid === 1'b1 && id_first_cyc < 0) id_first_cyc = cyc;

        tk = 0;
        if (rv) begin
            exp_q.delete();
            model_pc = rpc & 32'hFFFF_FFFC;
            if (pend_valid) begin
                if (resp) pend_valid = 0;
                else      pend_drop  = 1;
            end
        end else begin
            if (exp_q.size() != 0 && rdy) e = exp_q.pop_front();
            if (resp) begin
                pend_valid = 0;
                if (!pend_drop) begin
                    exp_q.push_back({pend_addr, w});
                    tk = (w[31:29] == 3'b110) && cond_ok(w[28:25], flags);
                    model_pc = tk ? ((pend_addr + {{16{w[15]}}, w[15:0]}) & 32'hFFFF_FFFC)
                                  : pend_addr + 32'd4;
                end
            end else if (exp_req) begin
                pend_valid = 1; pend_drop = 0; pend_addr = model_pc;
                pend_rem = $urandom_range(lat_min, lat_max);
                if (slow_en && model_pc == slow_addr) pend_rem = slow_lat;
                if (redir_arm && model_pc == redir_at_addr) begin
                    redir_arm = 0; redir_cnt = redir_delay;
                end
            end
        end
        exp_br = tk;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        imem_valid = 1'b1; imem_rdata = 32'hDC00_0010; id_ready = 1'b1; cond_flags = 4'hF;
        @(posedge clk); #1;
        repeat (2) begin
            @(posedge clk); #1;
            tests_run++;
            if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_imem_req got=%b exp=0", imem_req); end
            tests_run++;
            if (id_valid !== 1'b0) begin fails++; $display("FAIL rst_id_valid got=%b exp=0", id_valid); end
            tests_run++;
            if (br_taken !== 1'b0) begin fails++; $display("FAIL rst_br_taken got=%b exp=0", br_taken); end
            tests_run++;
            if (fetch_pc !== RST_PC) begin fails++; $display("FAIL rst_fetch_pc got=%h exp=%h", fetch_pc, RST_PC); end
        end
        reset = 1'b0; redirect_valid = 1'b0; imem_valid = 1'b0;
        #1;
        tests_run++;
        if (imem_req !== 1'b1) begin fails++; $display("FAIL post_rst_req got=%b exp=1", imem_req); end
        tests_run++;
        if (imem_addr !== RST_PC) begin fails++; $display("FAIL post_rst_addr got=%h exp=%h", imem_addr, RST_PC); end
    endtask

    task automatic test_fetch_stream();
        do_reset();
        repeat (10) cycle();
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (req_at(i) !== 32'(4 * i)) begin
                fails++; $display("FAIL stream_addr%0d got=%h exp=%h", i, req_at(i), 32'(4 * i));
            end
        end
        for (int i = 1; i < 3; i++) begin
            tests_run++;
            if (cyc_at(i) - cyc_at(i - 1) != 2) begin
                fails++; $display("FAIL stream_spacing%0d got=%0d exp=2", i, cyc_at(i) - cyc_at(i - 1));
            end
        end
        tests_run++;
        if (id_first_cyc != cyc_at(0) + 2) begin
            fails++; $display("FAIL stream_latency got=%0d exp=%0d", id_first_cyc, cyc_at(0) + 2);
        end
        tests_run++;
        if (pop_at(0) !== 64'h0) begin fails++; $display("FAIL stream_first_word got=%h exp=0", pop_at(0)); end
    endtask

    task automatic test_branch_al();
        do_reset();
        mem[32'h8] = 32'hDC00_0010;
        repeat (14) cycle();
        tests_run++;
        if (req_at(3) !== 32'h18) begin fails++; $display("FAIL al_target got=%h exp=00000018", req_at(3)); end
        tests_run++;
        if (br_cnt != 1) begin fails++; $display("FAIL al_br_pulses got=%0d exp=1", br_cnt); end
        tests_run++;
        if (pop_at(2) !== {32'h8, 32'hDC00_0010}) begin
            fails++; $display("FAIL al_queued got=%h exp=%h", pop_at(2), {32'h8, 32'hDC00_0010});
        end
    endtask

    task automatic test_cond_sweep();
        logic [31:0] cw [8];
        logic [3:0]  cf [8];
        logic [31:0] cn [8];
        int          ct [8];
        cw = '{32'hC000_FFF0, 32'hC000_FFF0, 32'hD000_FFF0, 32'hD000_FFF0,
               32'hD200_FFF0, 32'hD800_FFF0, 32'hD600_FFF0, 32'hDE00_0010};
        cf = '{4'b0010, 4'b0000, 4'b0100, 4'b0110, 4'b0110, 4'b1001, 4'b1000, 4'b1111};
        ct = '{1, 0, 1, 0, 1, 1, 1, 0};
        cn = '{32'h10, 32'h24, 32'h10, 32'h24, 32'h10, 32'h10, 32'h10, 32'h24};
        for (int i = 0; i < 8; i++) begin
            do_reset();
            mem[32'h20] = cw[i];
            flags = cf[i];
            redir_pcs.push_back(32'h20);
            repeat (8) cycle();
            tests_run++;
            if (req_at(1) !== cn[i]) begin
                fails++; $display("FAIL cond%0d_next got=%h exp=%h", i, req_at(1), cn[i]);
            end
            tests_run++;
            if (br_cnt != ct[i]) begin
                fails++; $display("FAIL cond%0d_br got=%0d exp=%0d", i, br_cnt, ct[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n0;
        do_reset();
        for (int i = 0; i < 4; i++) mem[32'(4 * i)] = 32'h0A00_0000 + 32'(i);
        ready_pct = 0;
        repeat (16) cycle();
        tests_run++;
        if (req_log.size() != 4) begin fails++; $display("FAIL bp_req_count got=%0d exp=4", req_log.size()); end
        tests_run++;
        if (imem_req !== 1'b0) begin fails++; $display("FAIL bp_req_low got=%b exp=0", imem_req); end
        tests_run++;
        if (id_instr !== 32'h0A00_0000) begin fails++; $display("FAIL bp_head got=%h exp=0a000000", id_instr); end
        ready_pct = 100;
        n0 = pop_log.size();
        repeat (4) cycle();
        tests_run++;
        if (pop_log.size() - n0 != 4) begin fails++; $display("FAIL bp_pops got=%0d exp=4", pop_log.size() - n0); end
        tests_run++;
        if (req_at(4) !== 32'h10) begin fails++; $display("FAIL bp_resume got=%h exp=00000010", req_at(4)); end
    endtask

    task automatic test_redirect();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            ready_pct = 0;
            slow_en = 1; slow_addr = 32'hC; slow_lat = (k == 0) ? 3 : 2;
            redir_arm = 1; redir_at_addr = 32'hC; redir_target = 32'h103; redir_delay = (k == 0) ? 1 : 2;
            repeat (16) cycle();
            tests_run++;
            if (req_at(4) !== 32'h100) begin fails++; $display("FAIL redir%0d_addr got=%h exp=00000100", k, req_at(4)); end
            tests_run++;
            if (cyc_at(4) - cyc_at(3) != ((k == 0) ? 4 : 3)) begin
                fails++; $display("FAIL redir%0d_gap got=%0d exp=%0d", k, cyc_at(4) - cyc_at(3), (k == 0) ? 4 : 3);
            end
            tests_run++;
            if (id_pc !== 32'h100 || id_valid !== 1'b1) begin
                fails++; $display("FAIL redir%0d_head got=%h/%b exp=00000100/1", k, id_pc, id_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        lat_min = 4; lat_max = 4;
        cycle();
        redir_pcs.push_back(32'h200);
        redir_pcs.push_back(32'h305);
        repeat (10) cycle();
        tests_run++;
        if (req_at(1) !== 32'h304) begin fails++; $display("FAIL b2b_addr got=%h exp=00000304", req_at(1)); end
        tests_run++;
        if (cyc_at(1) != 6) begin fails++; $display("FAIL b2b_cycle got=%0d exp=6", cyc_at(1)); end
        tests_run++;
        if (req_at(2) !== 32'h308) begin fails++; $display("FAIL b2b_next got=%h exp=00000308", req_at(2)); end
    endtask

    task automatic test_random();
        do_reset();
        mem_rand = 1; flags_rand = 1; ready_pct = 70;
        lat_min = 1; lat_max = 3; redir_pct = 4; spur_pct = 10;
        repeat (4000) cycle();
        tests_run++;
        if (pop_log.size() < 200) begin fails++; $display("FAIL rand_progress got=%0d exp>=200", pop_log.size()); end
        tests_run++;
        if (br_cnt == 0) begin fails++; $display("FAIL rand_branches got=%0d exp>0", br_cnt); end
    endtask

    initial begin
        reset_model();
        test_reset();
        test_fetch_stream();
        test_branch_al();
        test_cond_sweep();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
